// File: rtl/shiftreg_pkg.sv
// Shared types and line constants for the shift-register serial receiver.
package shiftreg_pkg;

  localparam int SR_WIDTH = 6;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/serial_frame_receiver6.sv
// Frame receiver for the shift register's serial output, one-entry output buffer.
// Build option: define RX_PARITY_CHECK_EN to check an even-parity bit before stop.
module serial_frame_receiver6
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             serial_bit,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  output logic             frame_error,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] asm_q, asm_d;
  logic             perr_q, perr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wvalid_q, wvalid_d;
  logic             ferr_q, ferr_d;
  logic             ovf_q, ovf_d;
  logic             deliver;
  logic             bad;
  logic             take;

  always_ff @(posedge clockpulse or posedge clear) begin
    if (clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      asm_q    <= '0;
      perr_q   <= 1'b0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      perr_q   <= perr_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    perr_d  = perr_q;
    deliver = 1'b0;
    bad     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serial_bit == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
          perr_d  = 1'b0;
        end
      end
      DATA: begin
        asm_d = {serial_bit, asm_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
`ifdef RX_PARITY_CHECK_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: begin
        perr_d  = ^{asm_q, serial_bit};
        state_d = STOP;
      end
      STOP: begin
        // a 1 here is a bad stop, never a fresh start bit
        state_d = IDLE;
        if (serial_bit == STOP_BIT && !perr_q) begin
          deliver = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign take = wvalid_q && word_ready;

  always_comb begin
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q && !take;
    ovf_d    = ovf_q;
    ferr_d   = bad;
    if (deliver) begin
      if (!wvalid_q || take) begin
        wdata_d  = asm_q;
        wvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  assign word_data   = wdata_q;
  assign word_valid  = wvalid_q;
  assign frame_error = ferr_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_serial_frame_receiver6.sv
// Directed and randomized frames against a frame-level buffer model.
module tb_serial_frame_receiver6;

  logic       clockpulse = 1'b0;
  logic       clear      = 1'b1;
  logic       serial_bit = 1'b0;
  logic       word_ready = 1'b0;
  logic [5:0] word_data;
  logic       word_valid;
  logic       frame_error;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  logic       m_valid = 1'b0;
  logic [5:0] m_data  = '0;
  logic       m_ferr  = 1'b0;
  logic       m_ovf   = 1'b0;

  serial_frame_receiver6 dut (
    .clockpulse (clockpulse),
    .clear      (clear),
    .serial_bit (serial_bit),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .frame_error(frame_error),
    .overflow   (overflow)
  );

  always #5 clockpulse = ~clockpulse;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, {7'b0, word_valid}, {7'b0, m_valid});
    check({tag, ".data"}, {2'b0, word_data}, {2'b0, m_data});
    check({tag, ".ferr"}, {7'b0, frame_error}, {7'b0, m_ferr});
    check({tag, ".ovf"}, {7'b0, overflow}, {7'b0, m_ovf});
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ferr  = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // one clock: drive, take the edge, advance model, compare
  task automatic tick(input logic sb, input logic rdy,
                      input logic is_end, input logic good,
                      input logic [5:0] w, input string tag);
    serial_bit = sb;
    word_ready = rdy;
    @(posedge clockpulse);
    m_ferr = 1'b0;
    if (m_valid && rdy) m_valid = 1'b0;
    if (is_end) begin
      if (!good) m_ferr = 1'b1;
      else if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = w;
      end else m_ovf = 1'b1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic send_frame(input logic [5:0] w,
                            input logic stop_ok,
                            input logic par_ok,
                            input logic rdy,
                            input logic rdy_end,
                            input string tag);
    logic good;
    good = stop_ok;
    tick(1'b1, rdy, 1'b0, 1'b0, w, tag);
    for (int i = 0; i < 6; i++)
      tick(w[i], rdy, 1'b0, 1'b0, w, tag);
`ifdef RX_PARITY_CHECK_EN
    good = stop_ok && par_ok;
    tick((^w) ^ !par_ok, rdy, 1'b0, 1'b0, w, tag);
`else
    if (!par_ok) good = stop_ok;
`endif
    tick(!stop_ok, rdy_end, 1'b1, good, w, tag);
  endtask

  task automatic idle(input int n, input logic rdy,
                      input string tag);
    for (int i = 0; i < n; i++)
      tick(1'b0, rdy, 1'b0, 1'b0, '0, tag);
  endtask

  task automatic do_clear(input string tag);
    #2 clear = 1'b1;
    model_reset();
    #1 check_all(tag);
    @(posedge clockpulse);
    #1 clear = 1'b0;
  endtask

  initial begin
    logic [5:0] w;
    logic       sok, pok, r, re;

    @(posedge clockpulse);
    @(posedge clockpulse);
    #1 check_all("reset");
    clear = 1'b0;

    // clear in the middle of a frame
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, "mid_start");
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, "mid_d0");
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0, "mid_d1");
    do_clear("mid_clear");
    send_frame(6'h2D, 1'b1, 1'b1, 1'b0, 1'b0, "w2d");
    idle(2, 1'b0, "w2d_hold");

    send_frame(6'h2D, 1'b1, 1'b1, 1'b1, 1'b1, "b2b_a");
    send_frame(6'h12, 1'b1, 1'b1, 1'b1, 1'b1, "b2b_b");
    idle(2, 1'b1, "b2b_idle");

    send_frame(6'h00, 1'b0, 1'b1, 1'b0, 1'b0, "stoperr");
    idle(2, 1'b0, "stoperr_idle");

    send_frame(6'h3F, 1'b1, 1'b1, 1'b0, 1'b0, "ovf_a");
    send_frame(6'h01, 1'b1, 1'b1, 1'b0, 1'b0, "ovf_b");
    idle(3, 1'b1, "ovf_drain");

    do_clear("clr2");
    send_frame(6'h05, 1'b1, 1'b1, 1'b0, 1'b0, "sim_a");
    send_frame(6'h2A, 1'b1, 1'b1, 1'b0, 1'b1, "sim_b");
    idle(2, 1'b0, "sim_hold");

`ifdef RX_PARITY_CHECK_EN
    idle(1, 1'b1, "par_drain");
    send_frame(6'h07, 1'b1, 1'b1, 1'b0, 1'b0, "par_ok");
    idle(1, 1'b1, "par_drain2");
    send_frame(6'h07, 1'b1, 1'b0, 1'b0, 1'b0, "par_bad");
    idle(1, 1'b0, "par_idle");
`endif

    do_clear("clr3");
    for (int k = 0; k < 60; k++) begin
      w   = 6'($urandom);
      sok = ($urandom_range(0, 3) != 0);
      pok = ($urandom_range(0, 3) != 0);
      r   = 1'($urandom);
      re  = 1'($urandom);
      idle($urandom_range(0, 2), 1'($urandom), "rnd_gap");
      send_frame(w, sok, pok, r, re, "rnd");
    end
    idle(3, 1'b1, "rnd_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
